// File: rtl/voxel_pixel_sink_pkg.sv
// voxel_pixel_sink_pkg
// Shared types for the GPU pixel sink: default geometry, the pixel word,
// the queued pixel request record and the sink FSM state encoding.
// No ports (package).
package voxel_pixel_sink_pkg;

  localparam int DEFAULT_H_RESOLUTION = 320;
  localparam int DEFAULT_V_RESOLUTION = 240;
  localparam int DEFAULT_PIXEL_BITS   = 16;
  localparam int DEFAULT_COL_BITS     = $clog2(DEFAULT_H_RESOLUTION);
  localparam int DEFAULT_ROW_BITS     = $clog2(DEFAULT_V_RESOLUTION);

  // State codes kept as plain constants so older code comparing raw bits
  // still lines up with the enum below.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  typedef enum logic [1:0] {
    SINK_RUN   = ST_RUN,
    SINK_FLUSH = ST_FLUSH,
    SINK_SWAP  = ST_SWAP
  } sink_state_e;

  typedef logic [DEFAULT_PIXEL_BITS-1:0] pixel_t;

  typedef struct packed {
    logic [DEFAULT_ROW_BITS-1:0] row;
    logic [DEFAULT_COL_BITS-1:0] col;
    pixel_t                      data;
  } pixel_req_t;

endpackage

// File: rtl/voxel_pixel_sink_pixel_fifo.sv
// pixel_fifo
// Synchronous FIFO with registered full/empty flags. Pushes while full and
// pops while empty are ignored. DEPTH must be a power of two so the pointers
// wrap naturally.
// Ports: clock, reset (async, active-high), push/push_data, pop/pop_data
// (show-ahead: pop_data is the head entry), full, empty.
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy, used to register the full/empty flags one edge early.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; the flags guard every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/voxel_pixel_sink.sv
// voxel_pixel_sink
// Avalon-MM write-only responder for the GPU pixel master. Each accepted
// halfword write is decoded into row/column, queued in pixel_fifo, and drained
// through a holding register into the back half of a double-buffered
// framebuffer. frame_done flushes the queue and swaps front/back buffers.
// Optional feature macro: VOXEL_PIXEL_SINK_BOUNDS_CHECK_EN (drop out-of-frame
// writes, count them, raise sticky error).
// Ports: clock, reset (async, active-high); s_address/s_writedata/s_write/
// s_waitrequest (Avalon slave); fb_wr_en/fb_wr_addr/fb_wr_data/fb_wr_ready
// (RAM write port); frame_done in, swap_done/front_buf out; idle, drop_count,
// error status.
module voxel_pixel_sink #(
  parameter int          H_RESOLUTION = 320,
  parameter int          V_RESOLUTION = 240,
  parameter int          PIXEL_BITS   = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h0800_0000,
  localparam int COL_BITS = $clog2(H_RESOLUTION),
  localparam int ROW_BITS = $clog2(V_RESOLUTION),
  localparam int IDX_BITS = $clog2(H_RESOLUTION * V_RESOLUTION)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           s_address,
  input  logic [PIXEL_BITS-1:0] s_writedata,
  input  logic                  s_write,
  output logic                  s_waitrequest,
  output logic                  fb_wr_en,
  output logic [IDX_BITS:0]     fb_wr_addr,
  output logic [PIXEL_BITS-1:0] fb_wr_data,
  input  logic                  fb_wr_ready,
  input  logic                  frame_done,
  output logic                  swap_done,
  output logic                  front_buf,
  output logic                  idle,
  output logic [15:0]           drop_count,
  output logic                  error
);

  import voxel_pixel_sink_pkg::*;

  localparam int REQ_BITS = ROW_BITS + COL_BITS + PIXEL_BITS;
  localparam logic [IDX_BITS-1:0] H_RES_IDX = IDX_BITS'(H_RESOLUTION);

  sink_state_e         state, next_state;
  logic [31:0]         offset;
  logic [COL_BITS-1:0] in_col, q_col;
  logic [ROW_BITS-1:0] in_row, q_row;
  logic [PIXEL_BITS-1:0] q_data;
  logic [REQ_BITS-1:0] push_word, pop_word;
  logic [IDX_BITS-1:0] pixel_index;
  logic                accept, push, pop, fifo_full, fifo_empty, out_free;
  logic                unused_offset_bits;

  // Halfword addressing: bit 0 of the offset is a byte lane and is dropped.
  assign offset             = s_address - BASE_ADDRESS;
  assign in_col             = offset[1 +: COL_BITS];
  assign in_row             = offset[COL_BITS+1 +: ROW_BITS];
  assign unused_offset_bits = ^{offset[0], offset[31:COL_BITS+ROW_BITS+1]};

  // Stall depends only on state and the registered full flag, never on
  // s_write, so the master sees a stable waitrequest.
  assign s_waitrequest = (state != SINK_RUN) || fifo_full;
  assign accept        = s_write && !s_waitrequest;
  assign push_word     = {in_row, in_col, s_writedata};

`ifdef VOXEL_PIXEL_SINK_BOUNDS_CHECK_EN
  logic in_range;

  assign in_range = (s_address >= BASE_ADDRESS) &&
                    (32'(in_col) < 32'(H_RESOLUTION)) &&
                    (32'(in_row) < 32'(V_RESOLUTION));
  assign push     = accept && in_range;

  // Out-of-frame writes are acknowledged but discarded; count them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      error      <= 1'b0;
    end else if (accept && !in_range) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      error <= 1'b1;
    end
  end
`else
  assign push       = accept;
  assign drop_count = '0;
  assign error      = 1'b0;
`endif

  pixel_fifo #(
    .WIDTH(REQ_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The holding register may take a new pixel when it is empty or its
  // current pixel is being accepted by the RAM this cycle.
  assign out_free    = !fb_wr_en || fb_wr_ready;
  assign pop         = !fifo_empty && out_free;
  assign {q_row, q_col, q_data} = pop_word;
  assign pixel_index = IDX_BITS'(q_row) * H_RES_IDX + IDX_BITS'(q_col);

  // Pixels always go to the back buffer, the one not being scanned out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else if (pop) begin
      fb_wr_en   <= 1'b1;
      fb_wr_addr <= {~front_buf, pixel_index};
      fb_wr_data <= q_data;
    end else if (fb_wr_ready) begin
      fb_wr_en   <= 1'b0;
    end
  end

  // FLUSH waits until both the queue and the holding register are empty
  // (or the last pixel is leaving this cycle) before swapping.
  always_comb begin
    next_state = state;
    case (state)
      SINK_RUN:   if (frame_done) next_state = SINK_FLUSH;
      SINK_FLUSH: if (fifo_empty && out_free) next_state = SINK_SWAP;
      SINK_SWAP:  next_state = SINK_RUN;
      default:    next_state = SINK_RUN;
    endcase
  end

  // front_buf flips on entry to SWAP so it already shows the new front
  // buffer while swap_done is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SINK_RUN;
      front_buf <= 1'b0;
    end else begin
      state <= next_state;
      if (state == SINK_FLUSH && next_state == SINK_SWAP) front_buf <= ~front_buf;
    end
  end

  assign swap_done = (state == SINK_SWAP);
  assign idle      = fifo_empty && !fb_wr_en && (state == SINK_RUN);

endmodule

// File: tb/tb_voxel_pixel_sink.sv
// tb_voxel_pixel_sink
// Self-checking bench for voxel_pixel_sink: table of single-pixel writes with
// hand-computed framebuffer addresses, then directed sequences for capacity,
// frame flush/swap, reset during flush, same-cycle write/frame_done, and the
// optional bounds check (VOXEL_PIXEL_SINK_BOUNDS_CHECK_EN).
module tb_voxel_pixel_sink;

  localparam logic [31:0] BASE = 32'h0800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_address = '0;
  logic [15:0] s_writedata = '0;
  logic        s_write = 1'b0;
  logic        s_waitrequest;
  logic        fb_wr_en;
  logic [17:0] fb_wr_addr;
  logic [15:0] fb_wr_data;
  logic        fb_wr_ready = 1'b1;
  logic        frame_done = 1'b0;
  logic        swap_done;
  logic        front_buf;
  logic        idle;
  logic [15:0] drop_count;
  logic        error;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic [17:0] exp_addr;
  } wr_vec_t;

  wr_vec_t vecs[6];

  voxel_pixel_sink dut (
    .clock         (clock),
    .reset         (reset),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .fb_wr_en      (fb_wr_en),
    .fb_wr_addr    (fb_wr_addr),
    .fb_wr_data    (fb_wr_data),
    .fb_wr_ready   (fb_wr_ready),
    .frame_done    (frame_done),
    .swap_done     (swap_done),
    .front_buf     (front_buf),
    .idle          (idle),
    .drop_count    (drop_count),
    .error         (error)
  );

  always #5 clock = ~clock;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [15:0] data);
    s_write     = wr;
    s_address   = addr;
    s_writedata = data;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_waitreq"}, s_waitrequest, 0);
    checkOutput({tag, "_en"}, fb_wr_en, 0);
    checkOutput({tag, "_addr"}, fb_wr_addr, 0);
    checkOutput({tag, "_data"}, fb_wr_data, 0);
    checkOutput({tag, "_swap"}, swap_done, 0);
    checkOutput({tag, "_front"}, front_buf, 0);
    checkOutput({tag, "_idle"}, idle, 1);
    checkOutput({tag, "_drop"}, drop_count, 0);
    checkOutput({tag, "_error"}, error, 0);
  endtask

  initial begin
    int n, got, first_k, last_k, swaps, swap_k, leaks, early;
    logic stalled;

    // row*320+col, MSB=1 since front_buf starts at 0
    vecs[0] = '{BASE + 32'h0000_080A, 16'hF800, {1'b1, 17'd645}};
    vecs[1] = '{BASE,                 16'h1234, {1'b1, 17'd0}};
    vecs[2] = '{BASE + 32'h0000_027E, 16'h07E0, {1'b1, 17'd319}};
    vecs[3] = '{BASE + 32'h0003_BE7E, 16'h001F, {1'b1, 17'd76799}};
    vecs[4] = '{BASE + 32'h0000_080B, 16'hAAAA, {1'b1, 17'd645}};
    vecs[5] = '{BASE + 32'h0000_0402, 16'h5555, {1'b1, 17'd321}};

    // Power-on reset
    repeat (3) @(negedge clock);
    checkResetState("por");
    reset = 1'b0;

    // Single writes: fb write appears after the edge following acceptance
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput("vec_waitreq", s_waitrequest, 0);
      applyStimulus(1'b1, vecs[i].addr, vecs[i].data);
      @(negedge clock);
      applyStimulus(1'b0, '0, '0);
      checkOutput("vec_latency", fb_wr_en, 0);
      @(negedge clock);
      checkOutput("vec_en", fb_wr_en, 1);
      checkOutput("vec_addr", fb_wr_addr, vecs[i].exp_addr);
      checkOutput("vec_data", fb_wr_data, vecs[i].data);
      @(negedge clock);
      checkOutput("vec_release", fb_wr_en, 0);
    end

    // Column 320 lies just outside the frame
    @(negedge clock);
    applyStimulus(1'b1, BASE + 32'h0000_0280, 16'h0F0F);
    checkOutput("oob_waitreq", s_waitrequest, 0);
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    @(negedge clock);
`ifdef VOXEL_PIXEL_SINK_BOUNDS_CHECK_EN
    checkOutput("oob_no_write", fb_wr_en, 0);
    checkOutput("oob_drop", drop_count, 1);
    checkOutput("oob_error", error, 1);
    applyStimulus(1'b1, BASE - 32'd2, 16'h0F0F);
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    @(negedge clock);
    checkOutput("below_no_write", fb_wr_en, 0);
    checkOutput("below_drop", drop_count, 2);
`else
    checkOutput("oob_write", fb_wr_en, 1);
    checkOutput("oob_addr", fb_wr_addr, {1'b1, 17'd320});
    checkOutput("oob_drop", drop_count, 0);
    checkOutput("oob_error", error, 0);
`endif
    @(negedge clock);

    // Capacity with the RAM stalled: register + FIFO_DEPTH entries
    fb_wr_ready = 1'b0;
    n = 0;
    stalled = 1'b0;
    for (int k = 0; k < 12 && !stalled; k++) begin
      @(negedge clock);
      if (s_waitrequest) stalled = 1'b1;
      else begin
        applyStimulus(1'b1, BASE + 32'(n * 2), 16'h0100 + 16'(n));
        n++;
      end
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("cap_accepted", n, 9);
    checkOutput("cap_stalled", stalled, 1);
    repeat (2) @(negedge clock);
    checkOutput("hold_en", fb_wr_en, 1);
    checkOutput("hold_data", fb_wr_data, 16'h0100);
    fb_wr_ready = 1'b1;
    got = 0;
    first_k = -1;
    last_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (fb_wr_en) begin
        checkOutput("drain_data", fb_wr_data, 16'h0100 + 16'(got));
        checkOutput("drain_addr", fb_wr_addr, {1'b1, 17'(got)});
        if (first_k < 0) first_k = k;
        last_k = k;
        got++;
      end
      @(negedge clock);
    end
    checkOutput("drain_count", got, 9);
    checkOutput("drain_back_to_back", last_k - first_k, 8);

    // Frame flush and swap with three pixels pending
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, BASE + 32'd3092 + 32'(2 * i), 16'h0A00 + 16'(i));
      @(negedge clock);
    end
    applyStimulus(1'b0, '0, '0);
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    checkOutput("flush_waitreq", s_waitrequest, 1);
    fb_wr_ready = 1'b1;
    got = 0;
    last_k = -1;
    swaps = 0;
    swap_k = -1;
    early = 0;
    for (int k = 0; k < 16; k++) begin
      if (fb_wr_en) begin
        checkOutput("flush_data", fb_wr_data, 16'h0A00 + 16'(got));
        checkOutput("flush_addr", fb_wr_addr, {1'b1, 17'd970 + 17'(got)});
        last_k = k;
        got++;
      end
      if (swap_done) begin
        swaps++;
        swap_k = k;
      end
      if (swap_k < 0 && !s_waitrequest) early++;
      @(negedge clock);
    end
    checkOutput("flush_count", got, 3);
    checkOutput("flush_swaps", swaps, 1);
    checkOutput("flush_swap_timing", swap_k, last_k + 1);
    checkOutput("flush_no_early_accept", early, 0);
    checkOutput("flush_front", front_buf, 1);
    checkOutput("flush_idle", idle, 1);

    // After the swap new pixels go to buffer 0
    applyStimulus(1'b1, BASE + 32'h0000_080A, 16'hBEEF);
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    @(negedge clock);
    checkOutput("newframe_en", fb_wr_en, 1);
    checkOutput("newframe_addr", fb_wr_addr, {1'b0, 17'd645});
    @(negedge clock);

    // Reset in the middle of a flush with four pixels still queued
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, BASE + 32'(2 * i), 16'h0C00 + 16'(i));
      @(negedge clock);
    end
    applyStimulus(1'b0, '0, '0);
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
    checkOutput("rst_in_flush", s_waitrequest, 1);
    #2 reset = 1'b1;
    #1 checkResetState("midrst");
    @(negedge clock);
    reset = 1'b0;
    fb_wr_ready = 1'b1;
    leaks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (fb_wr_en || swap_done) leaks++;
    end
    checkOutput("midrst_no_output", leaks, 0);
    checkOutput("midrst_front", front_buf, 0);

    // Write and frame_done together: pixel belongs to the old frame
    applyStimulus(1'b1, BASE + 32'h0000_080A, 16'h07E0);
    frame_done = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    frame_done = 1'b0;
    got = 0;
    last_k = -1;
    swap_k = -1;
    for (int k = 0; k < 12; k++) begin
      if (fb_wr_en) begin
        checkOutput("same_addr", fb_wr_addr, {1'b1, 17'd645});
        checkOutput("same_data", fb_wr_data, 16'h07E0);
        last_k = k;
        got++;
      end
      if (swap_done) swap_k = k;
      @(negedge clock);
    end
    checkOutput("same_count", got, 1);
    checkOutput("same_swap_after", swap_k, last_k + 1);
    checkOutput("same_front", front_buf, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
